// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Sits behind the nearest-neighbour scaler. Each (pixel, address) pair the
//   scaler offers is buffered in a small FIFO and then written to the VGA
//   framebuffer RAM port, which may stall. Frame completion and any dropped
//   input (FIFO refusal or out-of-range address) are reported upward.
//
//   Optional feature: define FB_CLEAR_EN to build a CLEAR phase that writes
//   zero to every framebuffer word after start, before streaming begins.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 arm a new frame (honoured only in IDLE or DONE)
//   in_valid/in_ready     scaler input handshake
//   in_pixel, in_addr     pixel and its framebuffer address
//   in_done               scaler frame-complete pulse
//   mem_we/mem_ready      RAM write handshake, mem_addr/mem_data payload
//   busy                  high outside IDLE/DONE
//   frame_done            one-cycle pulse once the last pixel is committed
//   overflow              sticky drop flag, cleared by an accepted start
//   dbg_state             current FSM state (IDLE=0 CLEAR=1 STREAM=2 DRAIN=3 DONE=4)
//
// Handshakes: a transfer happens on a rising edge where both sides are high
//   (in_valid & in_ready on the input, mem_we & mem_ready on the RAM side).
//   in_ready and mem_we never depend combinationally on in_valid or
//   mem_ready; mem_addr/mem_data stay stable while mem_we is high and the
//   write has not yet been accepted.
module framebuffer_writer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 16,
   parameter int FB_WORDS   = 307200
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pixel,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic [2:0]        dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W+1)'(FB_WORDS);
`ifdef FB_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
`ifdef FB_CLEAR_EN
      S_CLEAR  = 3'd1,
`endif
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state, state_next;

   // Each entry holds {address, pixel}.
   logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr, rd_ptr_nx1;
   // count includes the entry currently presented on the RAM port: an entry
   // is released only when its write commits, so the FIFO plus the output
   // register never hold more than FIFO_DEPTH pixels.
   logic [CNT_W-1:0]         count, count_next;

   logic addr_ok, push, fifo_commit, start_ok, ovf_event;

   always_comb begin
      addr_ok     = ({1'b0, in_addr} < FB_LIMIT);
      push        = in_valid && in_ready && addr_ok;
      start_ok    = start && (state == S_IDLE || state == S_DONE);
      ovf_event   = in_valid && (!in_ready || !addr_ok);
`ifdef FB_CLEAR_EN
      fifo_commit = mem_we && mem_ready && (state != S_CLEAR);
`else
      fifo_commit = mem_we && mem_ready;
`endif
      count_next  = count + CNT_W'(push) - CNT_W'(fifo_commit);
      rd_ptr_nx1  = rd_ptr + PTR_W'(1);
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
`ifdef FB_CLEAR_EN
               state_next = S_CLEAR;
`else
               state_next = S_STREAM;
`endif
            end
         end
`ifdef FB_CLEAR_EN
         S_CLEAR: begin
            // mem_addr doubles as the clear address counter.
            if (mem_ready && mem_addr == LAST_ADDR) state_next = S_STREAM;
         end
`endif
         S_STREAM: begin
            if (in_done) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // count == 0 also means no write is pending on the RAM port.
            if (count == '0) state_next = S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State, FIFO bookkeeping and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (push)        wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_commit) rd_ptr <= rd_ptr_nx1;
         // Registered from next state/count so in_ready always reflects the
         // count at the start of the cycle (a full FIFO refuses a push even
         // when a pop happens in the same cycle).
         in_ready   <= (state_next == S_STREAM) && (count_next < DEPTH_C);
         busy       <= !(state_next == S_IDLE || state_next == S_DONE);
         frame_done <= (state == S_DRAIN) && (state_next == S_DONE);
         if (start_ok)       overflow <= 1'b0;
         else if (ovf_event) overflow <= 1'b1;
      end
   end

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {in_addr, in_pixel};
   end

   // RAM drive stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
`ifdef FB_CLEAR_EN
         if (start_ok) begin
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= '0;
         end else if (state == S_CLEAR) begin
            if (mem_ready) begin
               if (mem_addr == LAST_ADDR) mem_we <= 1'b0;
               else                       mem_addr <= mem_addr + ADDR_W'(1);
            end
         end else
`endif
         if (fifo_commit) begin
            // Back-to-back: present the next entry in the commit cycle.
            if (count > CNT_W'(1)) {mem_addr, mem_data} <= fifo_mem[rd_ptr_nx1];
            else                   mem_we <= 1'b0;
         end else if (!mem_we && count != '0) begin
            mem_we               <= 1'b1;
            {mem_addr, mem_data} <= fifo_mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Testbench for framebuffer_writer: directed steps plus randomized frames,
// checked against a queue-based reference of the writer's behaviour.
module tb_framebuffer_writer;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 19;
   localparam int FIFO_DEPTH = 16;
`ifdef FB_CLEAR_EN
   localparam int FB_WORDS   = 64;
`else
   localparam int FB_WORDS   = 307200;
`endif
   localparam int W = ADDR_W + DATA_W;

   // Reference phases of a frame.
   localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_DONE = 3, P_CLEAR = 4;

   logic              clk = 1'b0;
   logic              reset_n, start, in_valid, in_done, mem_ready;
   logic              in_ready, mem_we, busy, frame_done, overflow;
   logic [DATA_W-1:0] in_pixel, mem_data;
   logic [ADDR_W-1:0] in_addr, mem_addr;
   logic [2:0]        dbg_state;

   framebuffer_writer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .FB_WORDS(FB_WORDS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .in_addr(in_addr), .in_done(in_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .busy(busy), .frame_done(frame_done), .overflow(overflow), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / reference ----------------
   int n_tests = 0, n_fail = 0;
   logic [W-1:0] exp_q[$];
   int       phase = P_IDLE;
   bit       ovf_m = 1'b0, fd_m = 1'b0, check_en = 1'b0;
   int       clr_m = 0;
   int       commits = 0, fd_cnt = 0, commits_at_fd = 0;
   int       first_push_cyc = -1, first_we_cyc = -1;
   bit       hold_v = 1'b0;
   logic [W-1:0] hold_w;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are compared against the reference state describing everything
   // up to now; then this cycle's inputs advance the reference for the edge.
   always @(negedge clk) begin
      if (check_en) begin
         int sz0, phase0;
         bit exp_rdy;
         logic [W-1:0] front;
         sz0     = exp_q.size();
         phase0  = phase;
         exp_rdy = (phase0 == P_STREAM) && (sz0 < FIFO_DEPTH);

         check_bit("in_ready", in_ready, exp_rdy);
         check_bit("busy", busy, phase0 == P_STREAM || phase0 == P_DRAIN || phase0 == P_CLEAR);
         check_bit("overflow", overflow, ovf_m);
         check_bit("frame_done", frame_done, fd_m);
         if (frame_done) begin
            fd_cnt++;
            commits_at_fd = commits;
         end
         if (hold_v) check_val("stall_hold", 64'({mem_we, mem_addr, mem_data}), 64'({1'b1, hold_w}));
         hold_v = mem_we && !mem_ready;
         hold_w = {mem_addr, mem_data};
         if (mem_we && first_we_cyc < 0) first_we_cyc = cyc;

         if (mem_we && mem_ready) begin
            commits++;
            if (phase0 == P_CLEAR) begin
               check_val("clear_word", 64'({mem_addr, mem_data}), 64'({ADDR_W'(clr_m), DATA_W'(0)}));
               clr_m++;
               if (clr_m == FB_WORDS) phase = P_STREAM;
            end else if (exp_q.size() == 0) begin
               check_bit("write_without_entry", mem_we, 1'b0);
            end else begin
               front = exp_q.pop_front();
               check_val("write", 64'({mem_addr, mem_data}), 64'(front));
            end
         end

         fd_m = 1'b0;
         if (in_valid) begin
            if (exp_rdy && int'(in_addr) < FB_WORDS) begin
               exp_q.push_back({in_addr, in_pixel});
               if (first_push_cyc < 0) first_push_cyc = cyc;
            end else begin
               ovf_m = 1'b1;
            end
         end
         if (start && (phase0 == P_IDLE || phase0 == P_DONE)) begin
            ovf_m = 1'b0;
`ifdef FB_CLEAR_EN
            phase = P_CLEAR;
            clr_m = 0;
`else
            phase = P_STREAM;
`endif
         end else if (in_done && phase0 == P_STREAM) begin
            phase = P_DRAIN;
         end else if (phase0 == P_DRAIN && sz0 == 0) begin
            phase = P_DONE;
            fd_m  = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4 * FB_WORDS + 200 && in_ready !== 1'b1; i++) begin
         if (i > 400) break;
         tick();
      end
      check_bit("arm_in_ready", in_ready, 1'b1);
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] p, input logic done);
      in_valid = 1'b1;
      in_addr  = a;
      in_pixel = p;
      in_done  = done;
      tick();
      in_valid = 1'b0;
      in_done  = 1'b0;
   endtask

   task automatic pulse_done();
      in_done = 1'b1;
      tick();
      in_done = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      int f0;
      f0 = fd_cnt;
      for (int i = 0; i < budget && fd_cnt == f0; i++) tick();
      tick();
      tick();
      check_val("frame_done_pulses", 64'(fd_cnt - f0), 64'd1);
   endtask

   task automatic reset_model();
      exp_q.delete();
      phase  = P_IDLE;
      ovf_m  = 1'b0;
      fd_m   = 1'b0;
      hold_v = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int c0;
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_done = 1'b0;
      in_pixel = '0; in_addr = '0; mem_ready = 1'b0;
      tick(); tick(); tick();

      // Reset values
      check_bit("rst_mem_we", mem_we, 1'b0);
      check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_val("rst_state", 64'(dbg_state), 64'd0);
      reset_n = 1'b1;
      reset_model();
      tick();
      check_en = 1'b1;

      // Stream of 8 pixels with the RAM always ready
      mem_ready = 1'b1;
      arm();
      first_push_cyc = -1;
      first_we_cyc   = -1;
      c0 = commits;
      for (int i = 0; i < 8; i++) push(ADDR_W'(i), DATA_W'(8'h10 + i), 1'b0);
      pulse_done();
      wait_frame(100);
      check_val("t2_writes", 64'(commits - c0), 64'd8);
      check_val("t2_writes_before_done", 64'(commits_at_fd - c0), 64'd8);
      check_val("t2_latency", 64'(first_we_cyc - first_push_cyc), 64'd2);
      check_bit("t2_overflow", overflow, 1'b0);

      // Backpressure: RAM stalled for 40 cycles while 20 pixels are offered
      arm();
      mem_ready = 1'b0;
      c0 = commits;
      for (int i = 0; i < 20; i++) push(ADDR_W'(100 + i), DATA_W'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) tick();
      check_bit("t3_overflow", overflow, 1'b1);
      check_val("t3_no_commit_stalled", 64'(commits - c0), 64'd0);
      mem_ready = 1'b1;
      pulse_done();
      wait_frame(100);
      check_val("t3_writes", 64'(commits - c0), 64'd16);

      // Out-of-range address
      arm();
      c0 = commits;
      push(ADDR_W'(FB_WORDS), 8'hAA, 1'b0);
      tick(); tick(); tick();
      check_bit("t4_overflow", overflow, 1'b1);
      check_val("t4_no_write", 64'(commits - c0), 64'd0);
      pulse_done();
      wait_frame(50);
      arm();
      check_bit("t4_overflow_cleared", overflow, 1'b0);

      // in_done together with the final pixel
      c0 = commits;
      push(ADDR_W'(10), 8'h5A, 1'b0);
      push(ADDR_W'(11), 8'h5B, 1'b0);
      push(ADDR_W'(12), 8'h5C, 1'b1);
      wait_frame(50);
      check_val("t5_writes_before_done", 64'(commits_at_fd - c0), 64'd3);

      // Randomized frames with random RAM stalls and occasional bad addresses
      for (int f = 0; f < 5; f++) begin
         mem_ready = 1'b1;
         arm();
         for (int c = 0; c < 60; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pixel  = DATA_W'($urandom);
            if ($urandom_range(0, 15) == 0) in_addr = ADDR_W'(FB_WORDS + $urandom_range(0, 5));
            else                            in_addr = ADDR_W'($urandom_range(0, FB_WORDS - 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            in_done   = (c == 59);
            tick();
         end
         in_valid  = 1'b0;
         in_done   = 1'b0;
         mem_ready = 1'b1;
         wait_frame(100);
      end

      // Reset in the middle of a stalled stream with 5 entries queued
      arm();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(ADDR_W'(200 + i), DATA_W'(i + 1), 1'b0);
      check_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_bit("t1_mem_we", mem_we, 1'b0);
      check_val("t1_mem_addr", 64'(mem_addr), 64'd0);
      check_val("t1_mem_data", 64'(mem_data), 64'd0);
      check_bit("t1_busy", busy, 1'b0);
      check_bit("t1_frame_done", frame_done, 1'b0);
      check_bit("t1_overflow", overflow, 1'b0);
      check_bit("t1_in_ready", in_ready, 1'b0);
      check_val("t1_state", 64'(dbg_state), 64'd0);
      tick();
      reset_n = 1'b1;
      reset_model();
      tick();
      check_en = 1'b1;

      // Recovery frame after reset: the aborted pixels must not appear
      mem_ready = 1'b1;
      arm();
      c0 = commits;
      push(ADDR_W'(300), 8'h33, 1'b0);
      push(ADDR_W'(301), 8'h34, 1'b1);
      wait_frame(50);
      check_val("t1_recovery_writes", 64'(commits - c0), 64'd2);
      check_val("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
